// File: rtl/countdown_timer_pkg.sv
// Shared mm:ss timing definitions: status encodings, limits and widths used by
// the countdown timer, the stopwatch and the display logic.
package countdown_timer_pkg;

  localparam int MIN_W   = 8;
  localparam int SEC_W   = 6;
  localparam int MAX_MIN = 99;
  localparam int MAX_SEC = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } status_e;

  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
    return (m > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : m;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : s;
  endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// mm:ss down counter: clamped preset load, decrement with seconds->minutes
// borrow, plus zero / one-second-left flags for the controlling FSM.
module mmss_down_counter
  import countdown_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [MIN_W-1:0] load_min_i,
  input  logic [SEC_W-1:0] load_sec_i,
  input  logic             dec_i,
  output logic [MIN_W-1:0] minutes_o,
  output logic [SEC_W-1:0] seconds_o,
  output logic             zero_o,
  output logic             last_o
);

  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;

  assign zero_o    = (min_q == '0) && (sec_q == '0);
  assign last_o    = (min_q == '0) && (sec_q == SEC_W'(1));
  assign minutes_o = min_q;
  assign seconds_o = sec_q;

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (clr_i) begin
      min_d = '0;
      sec_d = '0;
    end else if (load_i) begin
      min_d = clamp_min(load_min_i);
      sec_d = clamp_sec(load_sec_i);
    end else if (dec_i && !zero_o) begin
      // Borrow wraps seconds to 59; caller never decrements at 00:00.
      if (sec_q != '0) begin
        sec_d = sec_q - 1'b1;
      end else begin
        min_d = min_q - 1'b1;
        sec_d = SEC_W'(MAX_SEC);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      sec_q <= '0;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: command FSM, one-second prescaler and expiry pulse
// around an mmss_down_counter.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       status,
  output logic             expired
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  status_e       state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          exp_q, exp_d;
  logic          clr, ld, tick, zero, last;
  logic          start_cmd, pause_cmd;

  // start and pause together cancel each other out.
  assign start_cmd = start & ~pause;
  assign pause_cmd = pause & ~start;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr     = 1'b0;
    ld      = 1'b0;
    tick    = 1'b0;
    exp_d   = 1'b0;
    if (clear) begin
      clr     = 1'b1;
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (load && state_q != ST_RUNNING) begin
      ld      = 1'b1;
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start_cmd && !zero) state_d = ST_RUNNING;
        ST_PAUSED:  if (start_cmd) state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (pause_cmd) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
            tick    = 1'b1;
            presc_d = '0;
            if (last) begin
              state_d = ST_EXPIRED;
              exp_d   = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_EXPIRED: ;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      exp_q   <= exp_d;
    end
  end

  mmss_down_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .load_i     (ld),
    .load_min_i (load_min),
    .load_sec_i (load_sec),
    .dec_i      (tick),
    .minutes_o  (minutes),
    .seconds_o  (seconds),
    .zero_o     (zero),
    .last_o     (last)
  );

  assign status  = state_q;
  assign expired = exp_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one DUT with TICKS_PER_SEC=1 and one
// with TICKS_PER_SEC=4 share the same command inputs.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;

  logic [7:0] min1, min4;
  logic [5:0] sec1, sec4;
  logic [1:0] st1, st4;
  logic       exp1, exp4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .clear(clear),
    .minutes(min1), .seconds(sec1), .status(st1), .expired(exp1));

  countdown_timer #(.TICKS_PER_SEC(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .clear(clear),
    .minutes(min4), .seconds(sec4), .status(st4), .expired(exp4));

  // {minutes, seconds, status, expired}
  function automatic logic [16:0] pk(int m, int s, int st, int e);
    return {8'(m), 6'(s), 2'(st), 1'(e)};
  endfunction

  // Advance one edge and land 1 time unit after it; commands are single-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic do_load(int m, int s);
    load = 1'b1; load_min = 8'(m); load_sec = 6'(s);
    step();
  endtask

  task automatic test_reset();
    logic [16:0] exp_v;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load = 1'($urandom); start = 1'($urandom); pause = 1'($urandom);
      clear = 1'($urandom); load_min = 8'($urandom); load_sec = 6'($urandom);
      @(posedge clk); #1;
    end
    exp_v = pk(0, 0, 0, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL reset_tps1 got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    if ({min4, sec4, st4, exp4} !== exp_v) begin
      fails++; $display("FAIL reset_tps4 got %h want %h", {min4, sec4, st4, exp4}, exp_v);
    end
    tests++;
    load = 0; start = 0; pause = 0; clear = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    do_load(5, 0);
    start = 1'b1; step();
    step(); step();
    exp_v = pk(4, 58, 1, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL pre_async_rst got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    #2 rst = 1'b1;
    #1;
    exp_v = pk(0, 0, 0, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL async_rst got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    logic [16:0] exp_v;
    int rem;
    clear = 1'b1; step();
    do_load(1, 2);
    start = 1'b1; step();
    exp_v = pk(1, 2, 1, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL cd_start got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    for (int k = 1; k <= 62; k++) begin
      step();
      rem = 62 - k;
      exp_v = (rem == 0) ? pk(0, 0, 3, 1) : pk(rem / 60, rem % 60, 1, 0);
      if ({min1, sec1, st1, exp1} !== exp_v) begin
        fails++; $display("FAIL cd_tick%0d got %h want %h", k, {min1, sec1, st1, exp1}, exp_v);
      end
      tests++;
    end
    step();
    exp_v = pk(0, 0, 3, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL cd_pulse_end got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    start = 1'b1; step();
    step();
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL cd_start_in_expired got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
  endtask

  task automatic test_pause();
    logic [16:0] exp_v;
    clear = 1'b1; step();
    do_load(0, 5);
    start = 1'b1; step();
    step(); step();
    pause = 1'b1; step();
    exp_v = pk(0, 3, 2, 0);
    for (int i = 0; i < 10; i++) begin
      if ({min1, sec1, st1, exp1} !== exp_v) begin
        fails++; $display("FAIL pause_hold%0d got %h want %h", i, {min1, sec1, st1, exp1}, exp_v);
      end
      tests++;
      step();
    end
    start = 1'b1; step();
    exp_v = pk(0, 3, 1, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL pause_resume got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    for (int k = 2; k >= 0; k--) begin
      step();
      exp_v = (k == 0) ? pk(0, 0, 3, 1) : pk(0, k, 1, 0);
      if ({min1, sec1, st1, exp1} !== exp_v) begin
        fails++; $display("FAIL pause_after%0d got %h want %h", k, {min1, sec1, st1, exp1}, exp_v);
      end
      tests++;
    end
  endtask

  task automatic test_prescaler();
    logic [16:0] exp_v;
    clear = 1'b1; step();
    do_load(0, 2);
    start = 1'b1; step();
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_v = (k == 4) ? pk(0, 1, 1, 0) : pk(0, 2, 1, 0);
      if ({min4, sec4, st4, exp4} !== exp_v) begin
        fails++; $display("FAIL tps4_run%0d got %h want %h", k, {min4, sec4, st4, exp4}, exp_v);
      end
      tests++;
    end
    step(); step();
    pause = 1'b1; step();
    step(); step();
    exp_v = pk(0, 1, 2, 0);
    if ({min4, sec4, st4, exp4} !== exp_v) begin
      fails++; $display("FAIL tps4_paused got %h want %h", {min4, sec4, st4, exp4}, exp_v);
    end
    tests++;
    start = 1'b1; step();
    step();
    exp_v = pk(0, 1, 1, 0);
    if ({min4, sec4, st4, exp4} !== exp_v) begin
      fails++; $display("FAIL tps4_resume1 got %h want %h", {min4, sec4, st4, exp4}, exp_v);
    end
    tests++;
    step();
    exp_v = pk(0, 0, 3, 1);
    if ({min4, sec4, st4, exp4} !== exp_v) begin
      fails++; $display("FAIL tps4_resume2 got %h want %h", {min4, sec4, st4, exp4}, exp_v);
    end
    tests++;
  endtask

  task automatic test_clamp_and_ignore();
    logic [16:0] exp_v;
    clear = 1'b1; step();
    do_load(200, 63);
    exp_v = pk(99, 59, 0, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL clamp got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    clear = 1'b1; step();
    start = 1'b1; step();
    exp_v = pk(0, 0, 0, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL start_zero got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    do_load(0, 10);
    start = 1'b1; step();
    step();
    do_load(0, 50);
    exp_v = pk(0, 8, 1, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL load_running got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
  endtask

  task automatic test_priority();
    logic [16:0] exp_v;
    clear = 1'b1; load = 1'b1; start = 1'b1; load_min = 8'd0; load_sec = 6'd30;
    step();
    exp_v = pk(0, 0, 0, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL clr_ld_start got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
    load = 1'b1; start = 1'b1; load_min = 8'd0; load_sec = 6'd30;
    step();
    exp_v = pk(0, 30, 0, 0);
    if ({min1, sec1, st1, exp1} !== exp_v) begin
      fails++; $display("FAIL ld_start got %h want %h", {min1, sec1, st1, exp1}, exp_v);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_prescaler();
    test_clamp_and_ignore();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
